button_event_gen: RTL and testbench

//  Multi-channel button front end: synchronises, debounces and edge-detects N raw buttons,

---
 rtl/button_event_gen_if.sv | 22 ++
 rtl/button_event_gen.sv | 183 ++++++++++++++++++
 tb/tb_button_event_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_gen_if.sv
// Button front-end bus: sample tick, edge-mode select, raw buttons in; debounced level and event pulses out.
interface button_event_gen_if #(
    parameter int unsigned N_BTN = 4
);
    logic             en;
    logic [1:0]       edge_mode;
    logic [N_BTN-1:0] bt;
    logic [N_BTN-1:0] bt_level;
    logic [N_BTN-1:0] bt_flag;
    logic [N_BTN-1:0] long_flag;
    logic [N_BTN-1:0] repeat_flag;

    modport master (
        output en, edge_mode, bt,
        input  bt_level, bt_flag, long_flag, repeat_flag
    );

    modport slave (
        input  en, edge_mode, bt,
        output bt_level, bt_flag, long_flag, repeat_flag
    );
endinterface

// File: rtl/button_event_gen.sv
// Multi-channel button front end: 2-flop sync, en-gated debounce, edge flags,
// and a per-channel hold FSM producing long-press and auto-repeat pulses.
module button_event_gen #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_LEN    = 8,
    parameter int unsigned LONG_CNT   = 200,
    parameter int unsigned REPEAT_CNT = 50,
    parameter int unsigned REPEAT_EN  = 1
) (
    input  logic                clk_d,
    input  logic                rst,
    button_event_gen_if.slave   btn_bus
);

    localparam int unsigned DEB_W    = $clog2(DEB_LEN + 1);
    localparam int unsigned HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_LEN - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CNT - 1);

    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLD_PRESS,
        HOLD_LONG
    } hold_state_t;

    logic [N_BTN-1:0]  r_sync1;
    logic [N_BTN-1:0]  r_sync2;
    logic [N_BTN-1:0]  r_level;
    logic [N_BTN-1:0]  r_level_d;
    logic [N_BTN-1:0]  r_flag;
    logic [N_BTN-1:0]  r_long;
    logic [N_BTN-1:0]  r_rep;
    logic [DEB_W-1:0]  r_deb_cnt  [N_BTN];
    logic [HOLD_W-1:0] r_hold_cnt [N_BTN];
    hold_state_t       r_state    [N_BTN];

    logic [N_BTN-1:0]  w_level_nxt;
    logic [DEB_W-1:0]  w_deb_cnt_nxt  [N_BTN];
    logic [N_BTN-1:0]  w_rise;
    logic [N_BTN-1:0]  w_fall;
    logic [N_BTN-1:0]  w_flag_nxt;
    logic [N_BTN-1:0]  w_long_nxt;
    logic [N_BTN-1:0]  w_rep_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt [N_BTN];
    hold_state_t       w_state_nxt    [N_BTN];

    // Two-flop synchroniser, clocked every cycle regardless of en.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_bus.bt;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level after DEB_LEN consecutive differing en-samples.
    always_comb begin
        w_level_nxt   = r_level;
        w_deb_cnt_nxt = r_deb_cnt;
        if (btn_bus.en) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    w_deb_cnt_nxt[i] = '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    w_level_nxt[i]   = r_sync2[i];
                    w_deb_cnt_nxt[i] = '0;
                end else begin
                    w_deb_cnt_nxt[i] = r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level and counter registers.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_level   <= '0;
            r_deb_cnt <= '{default: '0};
        end else begin
            r_level   <= w_level_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
        end
    end

    // Edge select: edge_mode is sampled in the cycle the level differs from its delayed copy.
    always_comb begin
        w_rise = r_level & ~r_level_d;
        w_fall = ~r_level & r_level_d;
        case (btn_bus.edge_mode)
            2'b00:   w_flag_nxt = w_rise;
            2'b01:   w_flag_nxt = w_fall;
            2'b10:   w_flag_nxt = w_rise | w_fall;
            default: w_flag_nxt = '0;
        endcase
    end

    // Registered edge flag and delayed level.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_level_d <= '0;
            r_flag    <= '0;
        end else begin
            r_level_d <= r_level;
            r_flag    <= w_flag_nxt;
        end
    end

    // Hold FSM state register, hold counter and registered long/repeat pulses.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            r_state    <= '{default: HOLD_IDLE};
            r_hold_cnt <= '{default: '0};
            r_long     <= '0;
            r_rep      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_long     <= w_long_nxt;
            r_rep      <= w_rep_nxt;
        end
    end

    // Hold FSM next state; decisions use the level being registered this edge,
    // so a release landing on the count-reach tick suppresses the pulse.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_long_nxt     = '0;
        w_rep_nxt      = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            case (r_state[i])
                HOLD_IDLE: begin
                    if (w_level_nxt[i]) begin
                        w_state_nxt[i]    = HOLD_PRESS;
                        w_hold_cnt_nxt[i] = '0;
                    end
                end
                HOLD_PRESS: begin
                    if (!w_level_nxt[i]) begin
                        w_state_nxt[i]    = HOLD_IDLE;
                        w_hold_cnt_nxt[i] = '0;
                    end else if (btn_bus.en) begin
                        if (r_hold_cnt[i] == LONG_LAST) begin
                            w_long_nxt[i]     = 1'b1;
                            w_state_nxt[i]    = HOLD_LONG;
                            w_hold_cnt_nxt[i] = '0;
                        end else begin
                            w_hold_cnt_nxt[i] = r_hold_cnt[i] + 1'b1;
                        end
                    end
                end
                HOLD_LONG: begin
                    if (!w_level_nxt[i]) begin
                        w_state_nxt[i]    = HOLD_IDLE;
                        w_hold_cnt_nxt[i] = '0;
                    end else if (btn_bus.en) begin
                        if (r_hold_cnt[i] == REP_LAST) begin
                            w_rep_nxt[i]      = (REPEAT_EN != 0);
                            w_hold_cnt_nxt[i] = '0;
                        end else begin
                            w_hold_cnt_nxt[i] = r_hold_cnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i]    = HOLD_IDLE;
                    w_hold_cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    assign btn_bus.bt_level    = r_level;
    assign btn_bus.bt_flag     = r_flag;
    assign btn_bus.long_flag   = r_long;
    assign btn_bus.repeat_flag = r_rep;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with DEB_LEN=4, LONG_CNT=10, REPEAT_CNT=3.
module tb_button_event_gen;

    localparam int unsigned N = 4;

    logic clk_d = 1'b0;
    logic rst;

    button_event_gen_if #(.N_BTN(N)) ifc ();

    button_event_gen #(
        .N_BTN      (N),
        .DEB_LEN    (4),
        .LONG_CNT   (10),
        .REPEAT_CNT (3),
        .REPEAT_EN  (1)
    ) dut (
        .clk_d   (clk_d),
        .rst     (rst),
        .btn_bus (ifc)
    );

    always #5 clk_d = ~clk_d;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  bt;
        int unsigned cycles;
        logic [3:0]  exp_level;
        logic [15:0] exp_bt;
        logic [15:0] exp_long;
        logic [15:0] exp_rep;
    } vec_t;

    vec_t vecs [16];

    int checks = 0;
    int errors = 0;

    int unsigned cnt_bt   [N];
    int unsigned cnt_long [N];
    int unsigned cnt_rep  [N];
    int unsigned seg_edge;
    int unsigned first_bt, first_long, first_rep, last_rep;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input int unsigned c [N]);
        return {4'(c[3]), 4'(c[2]), 4'(c[1]), 4'(c[0])};
    endfunction

    task automatic clear_seg();
        for (int i = 0; i < N; i++) begin
            cnt_bt[i]   = 0;
            cnt_long[i] = 0;
            cnt_rep[i]  = 0;
        end
        seg_edge   = 0;
        first_bt   = 0;
        first_long = 0;
        first_rep  = 0;
        last_rep   = 0;
    endtask

    task automatic tick();
        @(posedge clk_d);
        #1;
        seg_edge++;
        for (int i = 0; i < N; i++) begin
            if (ifc.bt_flag[i]) begin
                cnt_bt[i]++;
                if (first_bt == 0) first_bt = seg_edge;
            end
            if (ifc.long_flag[i]) begin
                cnt_long[i]++;
                if (first_long == 0) first_long = seg_edge;
            end
            if (ifc.repeat_flag[i]) begin
                cnt_rep[i]++;
                if (first_rep == 0) first_rep = seg_edge;
                last_rep = seg_edge;
            end
        end
    endtask

    task automatic settle();
        ifc.bt        = '0;
        ifc.en        = 1'b1;
        ifc.edge_mode = 2'b00;
        repeat (20) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // press/release pairs; 10-cycle presses release exactly on the long boundary
        vecs[0]  = '{2'b00, 4'b0001, 10, 4'b0001, 16'h0001, 16'h0000, 16'h0000};
        vecs[1]  = '{2'b00, 4'b0000, 10, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{2'b00, 4'b0010, 10, 4'b0010, 16'h0010, 16'h0000, 16'h0000};
        vecs[3]  = '{2'b00, 4'b0000, 10, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{2'b01, 4'b0010, 10, 4'b0010, 16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{2'b01, 4'b0000, 10, 4'b0000, 16'h0010, 16'h0000, 16'h0000};
        vecs[6]  = '{2'b10, 4'b0010, 10, 4'b0010, 16'h0010, 16'h0000, 16'h0000};
        vecs[7]  = '{2'b10, 4'b0000, 10, 4'b0000, 16'h0010, 16'h0000, 16'h0000};
        vecs[8]  = '{2'b11, 4'b0010, 10, 4'b0010, 16'h0000, 16'h0000, 16'h0000};
        vecs[9]  = '{2'b11, 4'b0000, 10, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[10] = '{2'b10, 4'b1111, 10, 4'b1111, 16'h1111, 16'h0000, 16'h0000};
        vecs[11] = '{2'b10, 4'b0000, 10, 4'b0000, 16'h1111, 16'h0000, 16'h0000};
        vecs[12] = '{2'b11, 4'b0100, 11, 4'b0100, 16'h0000, 16'h0000, 16'h0000};
        vecs[13] = '{2'b11, 4'b0000, 10, 4'b0000, 16'h0000, 16'h0100, 16'h0000};
        vecs[14] = '{2'b11, 4'b0100, 10, 4'b0100, 16'h0000, 16'h0000, 16'h0000};
        vecs[15] = '{2'b11, 4'b0000, 10, 4'b0000, 16'h0000, 16'h0000, 16'h0000};

        rst           = 1'b1;
        ifc.en        = 1'b0;
        ifc.edge_mode = 2'b00;
        ifc.bt        = '0;
        clear_seg();
        repeat (3) @(posedge clk_d);
        #1;
        check("reset_outputs", {ifc.bt_level, ifc.bt_flag, ifc.long_flag, ifc.repeat_flag}, 16'h0);

        // Reset mid-press with all buttons held
        rst    = 1'b0;
        ifc.bt = 4'hF;
        ifc.en = 1'b1;
        clear_seg();
        repeat (8) tick();
        check("pre_rst_level", ifc.bt_level, 4'hF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {ifc.bt_level, ifc.bt_flag, ifc.long_flag, ifc.repeat_flag}, 16'h0);
        #1 rst = 1'b0;
        clear_seg();
        repeat (5) tick();
        check("rst_level_edge5", ifc.bt_level, 4'h0);
        tick();
        check("rst_level_edge6", ifc.bt_level, 4'hF);
        repeat (6) tick();
        check("rst_rise_flags", pack4(cnt_bt), 16'h1111);
        check("rst_rise_flag_edge", first_bt, 7);
        settle();

        // Table: edge modes, simultaneous channels, long-press boundary
        for (int k = 0; k < 16; k++) begin
            ifc.edge_mode = vecs[k].mode;
            ifc.bt        = vecs[k].bt;
            ifc.en        = 1'b1;
            clear_seg();
            repeat (vecs[k].cycles) tick();
            check($sformatf("v%0d_level", k), ifc.bt_level, vecs[k].exp_level);
            check($sformatf("v%0d_bt_flag", k), pack4(cnt_bt), vecs[k].exp_bt);
            check($sformatf("v%0d_long_flag", k), pack4(cnt_long), vecs[k].exp_long);
            check($sformatf("v%0d_repeat_flag", k), pack4(cnt_rep), vecs[k].exp_rep);
        end
        settle();

        // Bounce on ch0: 1,1,0,0 then held 1
        ifc.edge_mode = 2'b00;
        clear_seg();
        ifc.bt = 4'b0001;
        repeat (2) tick();
        ifc.bt = 4'b0000;
        repeat (2) tick();
        ifc.bt = 4'b0001;
        repeat (10) tick();
        check("bounce_flag_count", pack4(cnt_bt), 16'h0001);
        check("bounce_flag_edge", first_bt, 11);
        check("bounce_level", ifc.bt_level, 4'b0001);
        settle();

        // Long/repeat on ch2 with en every second cycle, then release
        ifc.edge_mode = 2'b11;
        clear_seg();
        for (int c = 1; c <= 70; c++) begin
            ifc.bt = (c <= 50) ? 4'b0100 : 4'b0000;
            ifc.en = (c % 2 == 1);
            tick();
        end
        check("hold_long_count", pack4(cnt_long), 16'h0100);
        check("hold_long_edge", first_long, 29);
        check("hold_rep_count", pack4(cnt_rep), 16'h0400);
        check("hold_rep_first", first_rep, 35);
        check("hold_rep_last", last_rep, 53);
        check("hold_release_level", ifc.bt_level, 4'b0000);
        settle();

        // en held low mid-debounce freezes the counter
        ifc.edge_mode = 2'b00;
        clear_seg();
        ifc.bt = 4'b0001;
        ifc.en = 1'b1;
        repeat (4) tick();
        ifc.en = 1'b0;
        repeat (50) tick();
        check("freeze_level_hold", ifc.bt_level, 4'b0000);
        check("freeze_no_flag", pack4(cnt_bt), 16'h0000);
        ifc.en = 1'b1;
        tick();
        check("freeze_resume_edge55", ifc.bt_level, 4'b0000);
        tick();
        check("freeze_resume_edge56", ifc.bt_level, 4'b0001);
        repeat (4) tick();
        check("freeze_flag_count", pack4(cnt_bt), 16'h0001);
        check("freeze_flag_edge", first_bt, 57);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
